// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - instruction sequencer feeding an external alu, with 4-entry register file and carry flag
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [8:0]   i_instr,
  input  logic [N-1:0] i_imm,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [1:0]   o_alu_op,
  input  logic [N-1:0] i_alu_out,
  input  logic         i_alu_carry,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [N-1:0] o_result,
  output logic         o_carry
);

  localparam int REGS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic         write_back;

  logic [N-1:0] rf [REGS];
  logic         carry_flag;
  logic         kind;
  logic [1:0]   rd;
  logic [N-1:0] imm;
  logic [N-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    o_ready     = 1'b0;
    o_res_valid = 1'b0;
    accept      = 1'b0;
    write_back  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        write_back = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are captured from the pre-accept register contents, so rd == ra/rb
  // aliasing naturally reads the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        rf[i] <= '0;
      end
      carry_flag <= 1'b0;
      kind       <= 1'b0;
      rd         <= 2'd0;
      imm        <= '0;
      result     <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= 2'b00;
    end else begin
      if (accept) begin
        kind     <= i_instr[8];
        o_alu_op <= i_instr[7:6];
        rd       <= i_instr[5:4];
        o_alu_a  <= rf[i_instr[3:2]];
        o_alu_b  <= rf[i_instr[1:0]];
        imm      <= i_imm;
      end
      if (write_back) begin
        if (kind) begin
          rf[rd] <= imm;
          result <= imm;
        end else begin
          rf[rd]     <= i_alu_out;
          result     <= i_alu_out;
          carry_flag <= i_alu_carry;
        end
      end
    end
  end

  assign o_result = result;
  assign o_carry  = carry_flag;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer that drives the `alu` block: it accepts one instruction per handshake, reads two operands from a small internal register file, and presents them and the opcode to the ALU. It captures the ALU result and carry back into the register file and a carry flag, then offers the result downstream on a valid/ready handshake. The `alu` is instantiated beside this block; its inputs come from `o_alu_*` and its outputs return on `i_alu_*`.

## Interface
- `N`, default 8: datapath width; must match the connected `alu #(N)`.
- `REGS`, fixed 4: register file depth, addressed by 2-bit fields.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `i_valid`, in, 1: instruction valid.
- `o_ready`, out, 1: instruction accepted when `i_valid && o_ready` at a rising edge.
- `i_instr`, in, 9: instruction word.
  - [8] = kind: 0 = ALU op, 1 = load immediate.
  - [7:6] = op: 00 add, 01 sub, 10 and, 11 or.
  - [5:4] = rd, [3:2] = ra, [1:0] = rb.
- `i_imm`, in, N: immediate value, used only when kind = 1.
- `o_alu_a`, out, N: ALU operand a (registered).
- `o_alu_b`, out, N: ALU operand b (registered).
- `o_alu_op`, out, 2: ALU opcode (registered).
- `i_alu_out`, in, N: ALU result (combinational from `o_alu_*`).
- `i_alu_carry`, in, 1: ALU carry out.
- `o_res_valid`, out, 1: result available.
- `i_res_ready`, in, 1: downstream consumes the result when `o_res_valid && i_res_ready`.
- `o_result`, out, N: written-back value.
- `o_carry`, out, 1: current carry flag.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
  - `o_ready` = 1 only in IDLE.
  - `o_res_valid` = 1 only in RESP.
- IDLE:
  - On accept, latch kind, op, rd and the immediate.
  - Load `o_alu_a` ← R[ra], `o_alu_b` ← R[rb] and `o_alu_op` ← op.
  - Go to EXEC.
  - Operands are read from the register contents before the accepting edge.
- EXEC (exactly one cycle):
  - For an ALU op: R[rd] ← `i_alu_out`, carry flag ← `i_alu_carry`, and `o_result` ← `i_alu_out`.
  - For a load: R[rd] ← imm and `o_result` ← imm; the carry flag is unchanged and `o_alu_*` are don't-care.
  - Go to RESP.
- RESP:
  - Hold `o_result` and `o_carry` stable.
  - On `i_res_ready` = 1, go to IDLE.
  - No new instruction is accepted in this state.
- `o_carry` always mirrors the stored carry flag.
  - For sub, carry = 1 means no borrow (a ≥ b).
  - For and/or, the value is whatever the ALU reports; it is stored without interpretation.
- rd may equal ra or rb: reads use pre-write values, and the write takes effect for the next instruction.
- Arithmetic wraps modulo 2^N; the block does no width extension.
- `i_instr` and `i_imm` are sampled only at the accepting edge; changes at other times are ignored.

## Timing
- Reset (`rst_n` = 0, asynchronous) forces:
  - state = IDLE, so `o_ready` = 1;
  - R[0..3] = 0 and carry flag = 0;
  - `o_alu_a` = `o_alu_b` = 0 and `o_alu_op` = 00;
  - `o_result` = 0, `o_res_valid` = 0, `o_carry` = 0.
- Reset mid-operation, in EXEC or RESP, aborts the instruction: no write-back, and the reset values apply immediately.
- Cycle-level sequence, with the accept edge E0:
  - E0 → EXEC, with `o_alu_*` valid during cycle E0..E1.
  - E1 → write-back and RESP; `o_res_valid` = 1 from just after E1.
  - Earliest consume edge is E2; earliest next accept is E3.
- Peak throughput is one instruction per 3 cycles with `i_res_ready` held at 1.
- Backpressure: RESP persists indefinitely while `i_res_ready` = 0, and all outputs stay stable.
- `i_res_ready` is ignored outside RESP.
- `i_valid` is ignored outside IDLE; the instruction is not queued.

## Test plan
- Reset check: assert `rst_n` = 0 asynchronously, mid-cycle.
  - Required response: all outputs at reset values at once, `o_ready` = 1.
  - Then issue an add of r0 + r1 → `o_result` = 0x00, `o_carry` = 0.
- Add with carry: load r0 = 0xBD and r1 = 0xA5, then add r2 = r0 + r1.
  - Required response: `o_result` = 0x62, `o_carry` = 1, and R[2] = 0x62 (confirm by adding r2 + r3, which gives 0x62).
- Sub and logic ops, with r0 = 0xBD and r1 = 0xA5:
  - sub → 0x18, `o_carry` = 1;
  - and → 0xA5;
  - or → 0xBD.
- Register aliasing: with r0 = 0x01, execute add r0 = r0 + r0 three times.
  - Required response: results 0x02, 0x04, 0x08.
- Backpressure: hold `i_res_ready` = 0 for 5 cycles in RESP, toggling `i_valid` and `i_instr` meanwhile.
  - Required response: `o_result` is stable, `o_ready` = 0, and no extra instruction executes.
  - After the release, next accept is one cycle later.
- Reset during EXEC of add r2 = r0 + r1: no write-back occurs.
  - Required response: subsequent add r3 = r2 + r2 gives 0x00.
